// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder
// Purpose  : Word-addressed data memory for the datapath memory stage. It takes
//            one load/store request at a time over a Req/Ready handshake and
//            inserts WAIT_STATES extra cycles before the access. Misaligned or
//            out-of-range requests complete with Error asserted.
// Ports    : CLK       - sole clock, rising edge
//            RST       - asynchronous active-high reset
//            Req       - request strobe, sampled only in IDLE
//            MemWrite  - 1 = store, 0 = load (latched with Req)
//            Address   - byte address (latched with Req)
//            WriteData - store data (latched with Req)
//            ReadData  - registered load result
//            Ready     - one-cycle completion pulse
//            Error     - request rejected, qualified by Ready
// Params   : N (data/address width), ADDR_BITS (word-index width),
//            WAIT_STATES (0..15)
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_responder #(
    parameter int N           = 32,
    parameter int ADDR_BITS   = 6,
    parameter int WAIT_STATES = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         Req,
    input  logic         MemWrite,
    input  logic [N-1:0] Address,
    input  logic [N-1:0] WriteData,
    output logic [N-1:0] ReadData,
    output logic         Ready,
    output logic         Error
);

    localparam int c_depth = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic                   r_we;
    logic [N-1:0]           r_addr;
    logic [N-1:0]           r_wdata;
    logic                   r_err;
    logic [N-1:0]           r_rdata;
    logic [N-1:0]           r_mem [c_depth];

    logic [ADDR_BITS-1:0]   w_idx;
    logic                   w_misaligned;
    logic                   w_out_of_range;
    logic                   w_err;

    // All decoding works on the latched address so that bus changes after
    // acceptance cannot influence the access.
    assign w_idx          = r_addr[ADDR_BITS+1:2];
    assign w_misaligned   = |r_addr[1:0];
    assign w_out_of_range = |(r_addr >> (ADDR_BITS + 2));
    assign w_err          = w_misaligned | w_out_of_range;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Req) begin
                        r_we    <= MemWrite;
                        r_addr  <= Address;
                        r_wdata <= WriteData;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        // Access is committed on the edge that leaves BUSY.
                        r_err <= w_err;
                        if (w_err) begin
                            r_rdata <= '0;
                        end else if (r_we) begin
                            r_mem[w_idx] <= r_wdata;
                        end else begin
                            r_rdata <= r_mem[w_idx];
                        end
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Always pass through IDLE so responses never abut.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ReadData = r_rdata;
    assign Ready    = (r_state == ST_RESP);
    assign Error    = (r_state == ST_RESP) && r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_responder
// Purpose  : Directed self-checking bench for data_memory_responder. One
//            instance uses WAIT_STATES = 2, a second uses WAIT_STATES = 0 for
//            the held-request throughput pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

    logic        clk;
    logic        rst;

    logic        req,  mw;
    logic [31:0] addr, wd;
    logic [31:0] rdata;
    logic        ready, error;

    logic        req0;
    logic [31:0] rdata0;
    logic        ready0, error0;

    int n_checks;
    int n_fail;

    data_memory_responder #(
        .N           (32),
        .ADDR_BITS   (6),
        .WAIT_STATES (2)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .Req       (req),
        .MemWrite  (mw),
        .Address   (addr),
        .WriteData (wd),
        .ReadData  (rdata),
        .Ready     (ready),
        .Error     (error)
    );

    data_memory_responder #(
        .N           (32),
        .ADDR_BITS   (6),
        .WAIT_STATES (0)
    ) dut0 (
        .CLK       (clk),
        .RST       (rst),
        .Req       (req0),
        .MemWrite  (1'b0),
        .Address   (32'h0),
        .WriteData (32'h0),
        .ReadData  (rdata0),
        .Ready     (ready0),
        .Error     (error0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One transaction on the WAIT_STATES = 2 instance. Address switches to
    // a_after right after acceptance. Returns latency in edges after the
    // accepting edge (-1 on timeout) and leaves the DUT back in IDLE.
    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] a_after,
                        output logic [31:0] rd, output logic e, output int lat);
        rd  = '0;
        e   = 1'b0;
        lat = -1;
        @(negedge clk);
        req  = 1'b1;
        mw   = we;
        addr = a;
        wd   = d;
        @(posedge clk);
        #1;
        req  = 1'b0;
        addr = a_after;
        wd   = ~d;
        mw   = ~we;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = k;
                rd  = rdata;
                e   = error;
                break;
            end
        end
        @(posedge clk);
        #1;
        chk("ready_one_cycle", {31'd0, ready}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;
    logic [8:0]  pat;
    logic        prev_ready0;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b1;
        req  = 1'b0; mw = 1'b0; addr = '0; wd = '0;
        req0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Store then load with latency check
        xact(1'b1, 32'h10, 32'h12345678, 32'h10, rd, e, lat);
        chk("st10_lat", 32'(lat), 32'd3);
        chk("st10_err", {31'd0, e}, 32'd0);
        chk("st10_rdata_kept", rd, 32'h0);
        xact(1'b0, 32'h10, 32'h0, 32'h10, rd, e, lat);
        chk("ld10_lat", 32'(lat), 32'd3);
        chk("ld10_data", rd, 32'h12345678);
        chk("ld10_err", {31'd0, e}, 32'd0);

        // Reset while BUSY on a store to 0x8
        @(negedge clk);
        req = 1'b1; mw = 1'b1; addr = 32'h8; wd = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_busy_rdata", rdata, 32'h0);
        chk("rst_busy_ready", {31'd0, ready}, 32'd0);
        chk("rst_busy_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        xact(1'b0, 32'h8, 32'h0, 32'h8, rd, e, lat);
        chk("ld8_after_rst", rd, 32'h0);
        chk("ld8_after_rst_err", {31'd0, e}, 32'd0);
        chk("ld8_after_rst_lat", 32'(lat), 32'd3);
        xact(1'b0, 32'h10, 32'h0, 32'h10, rd, e, lat);
        chk("ld10_cleared", rd, 32'h0);

        // Misaligned store must not touch word 1
        xact(1'b1, 32'h4, 32'h11112222, 32'h4, rd, e, lat);
        xact(1'b0, 32'h4, 32'h0, 32'h4, rd, e, lat);
        chk("ld4_pre", rd, 32'h11112222);
        xact(1'b1, 32'h6, 32'hFFFF0000, 32'h6, rd, e, lat);
        chk("st6_err", {31'd0, e}, 32'd1);
        chk("st6_rdata", rd, 32'h0);
        chk("st6_lat", 32'(lat), 32'd3);
        xact(1'b0, 32'h4, 32'h0, 32'h4, rd, e, lat);
        chk("ld4_post", rd, 32'h11112222);
        chk("ld4_post_err", {31'd0, e}, 32'd0);

        // Out-of-range accesses alias word 0 by index; they must be rejected
        xact(1'b1, 32'h0, 32'h0BADF00D, 32'h0, rd, e, lat);
        xact(1'b0, 32'h0, 32'h0, 32'h0, rd, e, lat);
        chk("ld0_pre", rd, 32'h0BADF00D);
        xact(1'b0, 32'h100, 32'h0, 32'h100, rd, e, lat);
        chk("ld100_err", {31'd0, e}, 32'd1);
        chk("ld100_rdata", rd, 32'h0);
        xact(1'b1, 32'h100, 32'h77777777, 32'h100, rd, e, lat);
        chk("st100_err", {31'd0, e}, 32'd1);
        xact(1'b0, 32'h0, 32'h0, 32'h0, rd, e, lat);
        chk("ld0_post", rd, 32'h0BADF00D);

        // Address changes after acceptance are ignored
        xact(1'b1, 32'h20, 32'hA5A5A5A5, 32'h20, rd, e, lat);
        xact(1'b1, 32'h24, 32'h5A5A5A5A, 32'h24, rd, e, lat);
        xact(1'b0, 32'h20, 32'h0, 32'h24, rd, e, lat);
        chk("ld20_latched", rd, 32'hA5A5A5A5);
        chk("ld20_err", {31'd0, e}, 32'd0);
        xact(1'b0, 32'h24, 32'h0, 32'h20, rd, e, lat);
        chk("ld24_data", rd, 32'h5A5A5A5A);

        // WAIT_STATES = 0 with Req held: Ready after edges 2, 5, 8
        pat = '0;
        prev_ready0 = 1'b0;
        @(negedge clk);
        req0 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            pat[k] = ready0;
            if (ready0) begin
                chk("w0_error", {31'd0, error0}, 32'd0);
                chk("w0_rdata", rdata0, 32'h0);
            end
            chk("w0_no_consecutive", {31'd0, ready0 & prev_ready0}, 32'd0);
            prev_ready0 = ready0;
        end
        @(negedge clk);
        req0 = 1'b0;
        chk("w0_pattern", {23'd0, pat}, 32'b0_1001_0010);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
